// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite responder backed by a DEPTH x DATA_WIDTH register file.
// Inserts WAIT_STATES data-phase wait cycles per accepted transfer, supports byte
// lane writes and answers illegal transfers with the two-cycle ERROR response.
// Ports:
//   hclk, hresetn          clock, asynchronous active-low reset
//   hsel, haddr, htrans,   address-phase controls (accepted when hsel & hready & htrans[1])
//   hwrite, hsize, hburst
//   hwdata, hwstrb         data-phase write data and byte strobes
//   hready                 bus-wide ready returned by the interconnect
//   hrdata                 read data, driven from the array during the completing cycle
//   hreadyout, hresp       slave ready and response (decoded from the state register)
module ahb_mem_slave #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned HBURST_WIDTH = 3
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      hsel,
  input  logic [ADDR_WIDTH-1:0]     haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [HBURST_WIDTH-1:0]   hburst,
  input  logic [DATA_WIDTH-1:0]     hwdata,
  input  logic [DATA_WIDTH/8-1:0]   hwstrb,
  input  logic                      hready,
  output logic [DATA_WIDTH-1:0]     hrdata,
  output logic                      hreadyout,
  output logic                      hresp
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_XFER = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        wait_cnt;
  logic [IDX_W-1:0]        lat_idx;
  logic                    lat_write;
  logic [NUM_LANES-1:0]    lat_mask;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    ready_phase_c;
  logic                    accept_c;
  logic                    illegal_c;
  logic [31:0]             word_full_c;
  logic [7:0]              lo_addr_c;
  logic [7:0]              size_mask_c;
  logic [31:0]             lane_off_c;
  logic [31:0]             lane_cnt_c;
  logic [NUM_LANES-1:0]    lane_mask_c;

  // Burst type and the BUSY/IDLE distinction are not needed by this responder.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  // A new address phase can only be taken while the slave is driving hreadyout high.
  assign ready_phase_c = (state == S_IDLE) || (state == S_XFER) || (state == S_ERR2);
  assign accept_c      = hsel & hready & htrans[1] & ready_phase_c;

  // Legality of the presented address phase.
  assign word_full_c = 32'(haddr >> LANE_BITS);
  assign lo_addr_c   = 8'(haddr);
  assign size_mask_c = (8'd1 << hsize) - 8'd1;
  assign illegal_c   = (word_full_c >= 32'(DEPTH)) ||
                       (hsize > 3'(LANE_BITS)) ||
                       (|(lo_addr_c & size_mask_c));

  // Byte lanes covered by the transfer: 2^hsize lanes starting at the address offset.
  assign lane_off_c = 32'(lo_addr_c) % NUM_LANES;
  assign lane_cnt_c = 32'd1 << hsize;

  always_comb begin
    lane_mask_c = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if ((i >= lane_off_c) && (i < lane_off_c + lane_cnt_c)) begin
        lane_mask_c[i] = 1'b1;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_XFER, S_ERR2: begin
        if (!accept_c) begin
          state_next = S_IDLE;
        end else if (illegal_c) begin
          state_next = S_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_next = S_XFER;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == CNT_W'(WAIT_STATES)) begin
          state_next = S_XFER;
        end
      end
      S_ERR1:  state_next = S_ERR2;
      default: state_next = S_IDLE;
    endcase
  end

  // State, registered response outputs, transfer latches and the memory array.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      wait_cnt  <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_mask  <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) begin
        mem[d] <= '0;
      end
    end else begin
      state     <= state_next;
      hreadyout <= !((state_next == S_WAIT) || (state_next == S_ERR1));
      hresp     <= (state_next == S_ERR1) || (state_next == S_ERR2);

      // Counter holds 1..WAIT_STATES while in WAIT, zero elsewhere.
      if (state_next == S_WAIT) begin
        wait_cnt <= (state == S_WAIT) ? wait_cnt + CNT_W'(1) : CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (accept_c) begin
        lat_idx   <= IDX_W'(word_full_c);
        lat_write <= hwrite;
        lat_mask  <= lane_mask_c;
      end

      // Write commits on the edge that ends the completing cycle, so a read
      // accepted on this same edge observes the new data.
      if ((state == S_XFER) && lat_write) begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
          if (hwstrb[l] && lat_mask[l]) begin
            mem[lat_idx][l*8 +: 8] <= hwdata[l*8 +: 8];
          end
        end
      end
    end
  end

  assign hrdata = (state == S_XFER) ? mem[lat_idx] : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: directed and randomized AHB-Lite traffic against ahb_mem_slave,
// checked against a word-array reference model with per-transfer timing rules.
module tb_ahb_mem_slave;

  localparam int unsigned WS = 1;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb_mem_slave #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(WS), .HBURST_WIDTH(3)
  ) u_dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
    .hready(hready), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } tx_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] ref_mem [256];
  tx_t         txq [$];
  logic [31:0] rd_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic tx_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                             input logic [2:0] sz, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    tx_t t;
    t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz; t.addr = a; t.wdata = d; t.strb = s;
    return t;
  endfunction

  // Reference rules: active when selected NONSEQ/SEQ; legal when in range, size fits
  // the bus and the address is naturally aligned.
  function automatic bit tx_active(input tx_t t);
    return t.sel && t.trans[1];
  endfunction

  function automatic bit tx_legal(input tx_t t);
    int unsigned idx = int'(t.addr) / 4;
    int unsigned nb  = 1 << t.size;
    if (idx >= 256) return 1'b0;
    if (t.size > 3'd2) return 1'b0;
    if ((int'(t.addr) % nb) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_write(input tx_t t);
    int unsigned idx = int'(t.addr) / 4;
    int unsigned off = int'(t.addr) % 4;
    int unsigned nb  = 1 << t.size;
    for (int unsigned b = 0; b < 4; b++) begin
      if (t.strb[b] && (b >= off) && (b < off + nb)) ref_mem[idx][b*8 +: 8] = t.wdata[b*8 +: 8];
    end
  endfunction

  task automatic drive_ap(input tx_t t);
    hsel   = t.sel;
    htrans = t.trans;
    hwrite = t.wr;
    hsize  = t.size;
    haddr  = t.addr;
    hburst = 3'($urandom);
  endtask

  // Observe one data phase from its first cycle until hreadyout is high.
  task automatic finish_dp(input tx_t t);
    bit          act       = tx_active(t);
    bit          leg       = act && tx_legal(t);
    int unsigned exp_stall = !act ? 0 : (leg ? WS : 1);
    logic        exp_err   = act && !leg;
    int unsigned stalls    = 0;
    while (hreadyout !== 1'b1) begin
      check("resp_in_wait", 32'(hresp), 32'(exp_err));
      stalls++;
      if (stalls > 20) begin
        check("stall_timeout", stalls, exp_stall);
        return;
      end
      @(negedge hclk);
    end
    check("stall_cycles", stalls, exp_stall);
    check("resp_done", 32'(hresp), 32'(exp_err));
    if (leg && !t.wr) begin
      check("rdata", hrdata, ref_mem[int'(t.addr) / 4]);
      rd_log.push_back(hrdata);
    end else if (!leg) begin
      check("rdata_zero", hrdata, 32'h0);
    end
    if (leg && t.wr) model_write(t);
  endtask

  // Pipelined master: each address phase overlaps the previous data phase.
  task automatic run_queue();
    tx_t dp;
    tx_t ap;
    bit  have_dp = 1'b0;
    int  n = txq.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) ap = txq[k];
      else ap = mk(1'b0, 2'd0, 1'b0, 3'd0, 16'h0, 32'h0, 4'h0);
      drive_ap(ap);
      if (have_dp) begin
        hwdata = dp.wdata;
        hwstrb = dp.strb;
        finish_dp(dp);
      end else begin
        hwdata = $urandom;
        hwstrb = 4'($urandom);
      end
      @(negedge hclk);
      dp = ap;
      have_dp = 1'b1;
    end
    txq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    hresetn = 1'b0;
    drive_ap(mk(1'b0, 2'd0, 1'b0, 3'd0, 16'h0, 32'h0, 4'h0));
    hwdata = 32'h0;
    hwstrb = 4'h0;
    repeat (3) @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'h1);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    hresetn = 1'b1;
    @(negedge hclk);

    // Full-word write then read back.
    rd_log.delete();
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 16'h0010, 32'hDEADBEEF, 4'hF));
    txq.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 16'h0010, 32'h0, 4'h0));
    run_queue();
    check("deadbeef", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'hDEADBEEF);

    // Single byte lane write over a known word.
    rd_log.delete();
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 16'h0010, 32'h11223344, 4'hF));
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd0, 16'h0011, 32'h0000AB00, 4'h2));
    txq.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 16'h0010, 32'h0, 4'h0));
    run_queue();
    check("byte_lane", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'h1122AB44);

    // Out-of-range read and misaligned halfword write leave memory untouched.
    rd_log.delete();
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 16'h0000, 32'h55667788, 4'hF));
    txq.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 16'h0400, 32'h0, 4'h0));
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd1, 16'h0001, 32'hFFFFFFFF, 4'hF));
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd3, 16'h0000, 32'hFFFFFFFF, 4'hF));
    txq.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 16'h0000, 32'h0, 4'h0));
    run_queue();
    check("err_no_write", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'h55667788);

    // Back-to-back write/read of the same word, BUSY in between reads.
    rd_log.delete();
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 16'h0024, 32'h0BADCAFE, 4'hF));
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 16'h0020, 32'hA5A50001, 4'hF));
    txq.push_back(mk(1'b1, 2'd3, 1'b0, 3'd2, 16'h0020, 32'h0, 4'h0));
    txq.push_back(mk(1'b1, 2'd1, 1'b0, 3'd2, 16'h0024, 32'h0, 4'h0));
    txq.push_back(mk(1'b1, 2'd3, 1'b0, 3'd2, 16'h0024, 32'h0, 4'h0));
    run_queue();
    check("raw_read", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'hA5A50001);
    check("seq_read", (rd_log.size() > 1) ? rd_log[1] : 32'hX, 32'h0BADCAFE);

    // Unselected NONSEQ write is ignored.
    rd_log.delete();
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 16'h0030, 32'h13579BDF, 4'hF));
    txq.push_back(mk(1'b0, 2'd2, 1'b1, 3'd2, 16'h0030, 32'hFFFFFFFF, 4'hF));
    txq.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 16'h0030, 32'h0, 4'h0));
    run_queue();
    check("hsel_low", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'h13579BDF);

    // Randomized traffic, mostly in a small window to provoke hazards.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 15) == 0) a = 16'($urandom);
      else a = 16'($urandom_range(0, 63));
      txq.push_back(mk(1'($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom),
                       3'($urandom_range(0, 3)), a, $urandom, 4'($urandom)));
    end
    run_queue();

    // Reset asserted in the middle of a wait state aborts the write.
    rd_log.delete();
    txq.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 16'h0014, 32'hCAFEF00D, 4'hF));
    run_queue();
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h0040;
    hwdata = 32'h12345678; hwstrb = 4'hF;
    @(negedge hclk);
    check("mid_wait_low", 32'(hreadyout), 32'h0);
    htrans = 2'd0;
    hsel = 1'b0;
    hresetn = 1'b0;
    #1;
    check("arst_hreadyout", 32'(hreadyout), 32'h1);
    check("arst_hresp", 32'(hresp), 32'h0);
    check("arst_hrdata", hrdata, 32'h0);
    repeat (3) @(negedge hclk);
    hresetn = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    @(negedge hclk);
    txq.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 16'h0014, 32'h0, 4'h0));
    txq.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 16'h0040, 32'h0, 4'h0));
    run_queue();
    check("post_rst_w5", (rd_log.size() > 0) ? rd_log[0] : 32'hX, 32'h0);
    check("post_rst_abort", (rd_log.size() > 1) ? rd_log[1] : 32'hX, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
